// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arbiter
//  Purpose  : Round-robin arbiter/sequencer that shares one shift-and-add
//             multiplier among NUM_REQ requesters. The winning requester's
//             operands are latched, the multiplier's start/busy handshake is
//             driven, and the product is returned with a one-cycle done pulse.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req                 - per-requester request level
//             req_m, req_n        - flattened operands, WIDTH bits per requester
//             grant               - one-hot, requester being served
//             done                - one-hot, one-cycle completion pulse
//             result              - product of the last completed operation
//             busy                - high whenever the arbiter is not idle
//             mult_start          - start request to the multiplier
//             mult_m, mult_n      - latched operands to the multiplier
//             mult_busy           - multiplier busy flag
//             mult_prod           - multiplier product (valid after busy falls)
//  Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_m,
    input  logic [NUM_REQ*WIDTH-1:0]   req_n,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [2*WIDTH-1:0]         result,
    output logic                       busy,
    output logic                       mult_start,
    output logic [WIDTH-1:0]           mult_m,
    output logic [WIDTH-1:0]           mult_n,
    input  logic                       mult_busy,
    input  logic [2*WIDTH-1:0]         mult_prod
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW-1:0] C_PTR_RESET = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic [IDXW-1:0]        rr_ptr_q,     rr_ptr_d;
    logic [IDXW-1:0]        winner_q,     winner_d;
    logic [NUM_REQ-1:0]     grant_q,      grant_d;
    logic [NUM_REQ-1:0]     done_q,       done_d;
    logic [2*WIDTH-1:0]     result_q,     result_d;
    logic                   busy_q,       busy_d;
    logic                   mult_start_q, mult_start_d;
    logic [WIDTH-1:0]       mult_m_q,     mult_m_d;
    logic [WIDTH-1:0]       mult_n_q,     mult_n_d;

    // Unpacked views of the flattened operand buses.
    logic [WIDTH-1:0]       m_arr [NUM_REQ];
    logic [WIDTH-1:0]       n_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign m_arr[k] = req_m[k*WIDTH +: WIDTH];
        assign n_arr[k] = req_n[k*WIDTH +: WIDTH];
    end

    // Round-robin search: start one past the last served requester and wrap,
    // so the requester served last has the lowest priority this round.
    logic                   found;
    logic [IDXW-1:0]        sel;

    always_comb begin
        int              idx;
        logic [IDXW-1:0] idx_c;
        idx   = 0;
        idx_c = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_c = IDXW'(idx);
            if (!found && req[idx_c]) begin
                found = 1'b1;
                sel   = idx_c;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        winner_d     = winner_q;
        grant_d      = grant_q;
        done_d       = '0;
        result_d     = result_q;
        mult_start_d = mult_start_q;
        mult_m_d     = mult_m_q;
        mult_n_d     = mult_n_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d      = sel;
                    grant_d       = '0;
                    grant_d[sel]  = 1'b1;
                    mult_m_d      = m_arr[sel];
                    mult_n_d      = n_arr[sel];
                    // Start is registered, so it is raised on entry to ISSUE.
                    mult_start_d  = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                // Hold start until the multiplier acknowledges with busy.
                if (mult_busy) begin
                    mult_start_d = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                mult_start_d = 1'b0;
                if (!mult_busy) begin
                    result_d = mult_prod;
                    done_d   = grant_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                grant_d  = '0;
                rr_ptr_d = winner_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= C_PTR_RESET;
            winner_q     <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            mult_start_q <= 1'b0;
            mult_m_q     <= '0;
            mult_n_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            winner_q     <= winner_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            mult_start_q <= mult_start_d;
            mult_m_q     <= mult_m_d;
            mult_n_q     <= mult_n_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign mult_start = mult_start_q;
    assign mult_m     = mult_m_q;
    assign mult_n     = mult_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_arbiter
//  Purpose  : Self-checking bench for mult_arbiter with a behavioural
//             start/busy multiplier and a done-driven scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*WIDTH-1:0] req_m = '0;
    logic [NUM_REQ*WIDTH-1:0] req_n = '0;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [2*WIDTH-1:0]       result;
    logic                     busy;
    logic                     mult_start;
    logic [WIDTH-1:0]         mult_m;
    logic [WIDTH-1:0]         mult_n;
    logic                     mult_busy;
    logic [2*WIDTH-1:0]       mult_prod;

    int tests  = 0;
    int errors = 0;

    // Expected completions: {one-hot done, product}
    logic [NUM_REQ+2*WIDTH-1:0] exp_q [$];

    mult_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_m      (req_m),
        .req_n      (req_n),
        .grant      (grant),
        .done       (done),
        .result     (result),
        .busy       (busy),
        .mult_start (mult_start),
        .mult_m     (mult_m),
        .mult_n     (mult_n),
        .mult_busy  (mult_busy),
        .mult_prod  (mult_prod)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: busy rises two cycles after start is seen in
    // the wait state, stays high four cycles, product is junk while busy.
    logic [1:0]       mst;
    logic [2:0]       mcnt;
    logic [WIDTH-1:0] pm, pn;

    always @(posedge clk) begin
        if (rst) begin
            mst       <= 2'd0;
            mcnt      <= 3'd0;
            mult_busy <= 1'b0;
            mult_prod <= '0;
            pm        <= '0;
            pn        <= '0;
        end else begin
            case (mst)
                2'd0: if (mult_start) begin
                    pm   <= mult_m;
                    pn   <= mult_n;
                    mcnt <= 3'd1;
                    mst  <= 2'd1;
                end
                2'd1: if (mcnt == 3'd0) begin
                    mult_busy <= 1'b1;
                    mult_prod <= 8'hA5;
                    mcnt      <= 3'd3;
                    mst       <= 2'd2;
                end else begin
                    mcnt <= mcnt - 3'd1;
                end
                default: if (mcnt == 3'd0) begin
                    mult_busy <= 1'b0;
                    mult_prod <= 8'(pm) * 8'(pn);
                    mst       <= 2'd0;
                end else begin
                    mcnt <= mcnt - 3'd1;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected entry.
    always @(negedge clk) begin
        if (!rst && done != '0) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=%b result=%0d, expected no done", done, result);
            end else begin
                logic [NUM_REQ+2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (done !== e[2*WIDTH +: NUM_REQ] || result !== e[2*WIDTH-1:0]) begin
                    errors++;
                    $display("FAIL done_result: done=%b result=%0d, expected done=%b result=%0d",
                             done, result, e[2*WIDTH +: NUM_REQ], e[2*WIDTH-1:0]);
                end
            end
        end
    end

    task automatic set_ops(input int k, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] n);
        req_m[k*WIDTH +: WIDTH] = m;
        req_n[k*WIDTH +: WIDTH] = n;
    endtask

    task automatic push_exp(input int k, input logic [2*WIDTH-1:0] res);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        exp_q.push_back({oh, res});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait for n done pulses; optionally drop each served request at its done.
    task automatic wait_dones(input int n, input bit clear_each, input string name);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done != '0) begin
                cnt++;
                if (clear_each) req = req & ~done;
            end
        end
        req = '0;
        if (cnt < n) begin
            tests++;
            errors++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, cnt, n);
        end
    endtask

    task automatic wait_mult_busy(input string name);
        int cyc = 0;
        while (!mult_busy && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!mult_busy) begin
            tests++;
            errors++;
            $display("FAIL %s_busy_timeout: mult_busy=0, expected 1", name);
        end
    endtask

    task automatic idle_check(input string name);
        @(posedge clk);
        #1;
        check({name, "_busy"},  busy,  0);
        check({name, "_grant"}, grant, 0);
    endtask

    initial begin
        do_reset();
        check("rst_grant",      grant,      0);
        check("rst_done",       done,       0);
        check("rst_result",     result,     0);
        check("rst_busy",       busy,       0);
        check("rst_mult_start", mult_start, 0);
        check("rst_mult_m",     mult_m,     0);
        check("rst_mult_n",     mult_n,     0);

        // Single request: 3*5
        set_ops(0, 4'd3, 4'd5);
        req = 4'b0001;
        push_exp(0, 8'd15);
        @(posedge clk);
        #1;
        check("single_grant",      grant,      4'b0001);
        check("single_mult_start", mult_start, 1);
        check("single_busy",       busy,       1);
        check("single_mult_m",     mult_m,     3);
        check("single_mult_n",     mult_n,     5);
        wait_dones(1, 1'b1, "single");
        idle_check("single_idle");
        check("single_result_held", result, 15);

        // Boundary operands
        set_ops(2, 4'd15, 4'd15);
        req = 4'b0100;
        push_exp(2, 8'd225);
        wait_dones(1, 1'b1, "max");
        idle_check("max_idle");
        set_ops(1, 4'd0, 4'd9);
        req = 4'b0010;
        push_exp(1, 8'd0);
        wait_dones(1, 1'b1, "zero");
        idle_check("zero_idle");

        // Simultaneous requests out of reset: 0 then 2
        do_reset();
        set_ops(0, 4'd2, 4'd3);
        set_ops(2, 4'd4, 4'd5);
        req = 4'b0101;
        push_exp(0, 8'd6);
        push_exp(2, 8'd20);
        wait_dones(2, 1'b1, "simul");
        idle_check("simul_idle");

        // Round-robin fairness with all requests held
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            set_ops(k, 4'(k + 1), 4'(k + 2));
        end
        req = 4'b1111;
        push_exp(0, 8'd2);
        push_exp(1, 8'd6);
        push_exp(2, 8'd12);
        push_exp(3, 8'd20);
        push_exp(0, 8'd2);
        push_exp(1, 8'd6);
        wait_dones(6, 1'b0, "rr");
        idle_check("rr_idle");

        // Request dropped mid-operation
        set_ops(1, 4'd5, 4'd6);
        req = 4'b0010;
        push_exp(1, 8'd30);
        wait_mult_busy("drop");
        @(posedge clk);
        #1;
        req = '0;
        check("drop_grant_kept", grant, 4'b0010);
        wait_dones(1, 1'b1, "drop");
        idle_check("drop_idle");

        // Reset while in RUN: no done may appear
        set_ops(0, 4'd9, 4'd9);
        req = 4'b0001;
        wait_mult_busy("rstrun");
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        check("rstrun_grant",      grant,      0);
        check("rstrun_done",       done,       0);
        check("rstrun_busy",       busy,       0);
        check("rstrun_mult_start", mult_start, 0);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        set_ops(3, 4'd7, 4'd6);
        req = 4'b1000;
        push_exp(3, 8'd42);
        wait_dones(1, 1'b1, "post_rst");
        idle_check("post_rst_idle");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one shift-and-add multiplier among NUM_REQ requesters.
- Each requester supplies a pair of operands and holds its request. The arbiter grants one requester, latches its operands, and drives the multiplier's start/busy handshake.
- When the multiplier finishes, the arbiter returns the product to the granted requester with a one-cycle done pulse.
- The block sits between the requester blocks and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until the matching done.
- req_m  in  NUM_REQ*WIDTH  flattened multiplicands; requester k uses bits [k*WIDTH +: WIDTH].
- req_n  in  NUM_REQ*WIDTH  flattened multipliers; same packing as req_m.
- grant  out  NUM_REQ  one-hot; identifies the requester currently being served.
- done  out  NUM_REQ  one-hot, one-cycle pulse; result is valid in that cycle.
- result  out  2*WIDTH  product of the last completed operation; held until the next done.
- busy  out  1  high whenever the arbiter is not in IDLE.
- mult_start  out  1  start request to the multiplier.
- mult_m  out  WIDTH  multiplicand to the multiplier (latched value).
- mult_n  out  WIDTH  multiplier operand to the multiplier (latched value).
- mult_busy  in  1  multiplier busy flag; rises about 2 cycles after start is seen.
- mult_prod  in  2*WIDTH  multiplier product; valid once mult_busy has fallen.

Behaviour:
- Reset values: grant=0, done=0, result=0, busy=0, mult_start=0, mult_m=0, mult_n=0, state=IDLE, rr_ptr=NUM_REQ-1. With rr_ptr at NUM_REQ-1, requester 0 has highest priority first.
- While rst is high, mult_start stays low. The multiplier is expected to settle in its wait state during this time.
- All outputs are registered.
- State machine:
  - IDLE: if any req bit is set, select the winner by searching from rr_ptr+1 upward with wrap-around. Latch that requester's req_m/req_n into mult_m/mult_n, set grant[winner], and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mult_start=1. Once mult_busy==1 is sampled, clear mult_start and go to RUN. mult_start may therefore stay high for several cycles; the multiplier ignores it once it has left its wait state.
  - RUN: mult_start=0. Once mult_busy==0 is sampled, load result<=mult_prod, set done[winner]=1, and go to DONE.
  - DONE: done is high for exactly this cycle. On exit clear done and grant, set rr_ptr<=winner, and go to IDLE.
- Operand stability: mult_m/mult_n do not change from grant until the next IDLE selection.
- Requester inputs are sampled only in the IDLE selection cycle.
- Dropping req mid-operation does not abort. The operation completes and done still pulses to that requester.
- A req still high in the cycle after done counts as a new request. It competes with the updated rr_ptr, so a lone requester is re-served and contending requesters are served first.
- Arbitration overhead: one selection cycle in IDLE plus one cycle in DONE, on top of the multiplier latency.
- There are no back-to-back grants without passing through IDLE.
- Arithmetic: result is the full 2*WIDTH-bit product with no truncation; 15*15=225 at WIDTH=4.
- Reset mid-operation: all state returns to reset values on the next edge and no done is issued. The multiplier's own state is not reset by this block; the integration guarantees that rst also covers the multiplier.
- req bits for unused requesters must be tied to 0. The arbiter never grants a requester whose req is low at selection.

Test Plan:
- Single request: req=0001, req_m[0]=3, req_n[0]=5 → grant=0001 next cycle; mult_start high until mult_busy rises; done=0001 for one cycle with result=15; busy returns low.
- Boundary operands: requester 2, m=15, n=15 → result=225. Requester 1, m=0, n=9 → result=0.
- Simultaneous requests out of reset: req=0101 → requester 0 served first, then requester 2. Exactly one done pulse each, in that order.
- Round-robin fairness: req=1111 held continuously, each requester with distinct operands (k+1)*(k+2) → service order 0,1,2,3,0,1; each result correct (2, 6, 12, 20).
- Request dropped mid-operation: requester 1 lowers req during RUN → operation completes, done=0010 with the correct product, then IDLE.
- Reset in RUN: assert rst for one cycle → grant, done, busy and mult_start are 0 on the next cycle and no done pulse appears. A subsequent request (m=7, n=6) completes with result=42.
